// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// master: producer+consumer side; slave: the pipeline.
interface addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, sat, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, sat, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/subtract, CHUNK bits per stage,
// carry registered between stages, optional signed saturation.
module addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic          ena,
    addsub_pipe_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMAX = ~SMIN;

    logic             adv;

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] r_q   [STAGES];
    logic             sat_q [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];

    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] r_d   [STAGES];
    logic             sat_d [STAGES];
    logic             c_d   [STAGES];
    logic             v_d   [STAGES];

    logic [WIDTH-1:0] a_s   [STAGES];
    logic [WIDTH-1:0] b_s   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             sat_s [STAGES];
    logic             c_s   [STAGES];
    logic             v_s   [STAGES];

    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] raw;
    logic             ovf_w;

    assign adv          = ena & (~v_q[LAST] | bus.out_ready);
    assign bus.in_ready = adv;

    // Stage 0 is fed from the port; b is inverted and carry-in set for sub.
    always_comb begin
        a_s[0]   = bus.a;
        b_s[0]   = bus.sub ? ~bus.b : bus.b;
        r_s[0]   = '0;
        sat_s[0] = bus.sat;
        c_s[0]   = bus.sub;
        v_s[0]   = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_s[k]   = a_q[k-1];
            b_s[k]   = b_q[k-1];
            r_s[k]   = r_q[k-1];
            sat_s[k] = sat_q[k-1];
            c_s[k]   = c_q[k-1];
            v_s[k]   = v_q[k-1];
        end
    end

    always_comb begin
        slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, a_s[k][k*CHUNK +: CHUNK]}
                  + {1'b0, b_s[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, c_s[k]};
            a_d[k]   = a_s[k];
            b_d[k]   = b_s[k];
            sat_d[k] = sat_s[k];
            v_d[k]   = v_s[k];
            r_d[k]   = r_s[k];
            r_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
            c_d[k]   = slice[CHUNK];
        end
    end

    // Bubbles shift along with valid data; a stall freezes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                r_q[k]   <= '0;
                sat_q[k] <= 1'b0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                r_q[k]   <= r_d[k];
                sat_q[k] <= sat_d[k];
                c_q[k]   <= c_d[k];
                v_q[k]   <= v_d[k];
            end
        end
    end

    // Flags are decoded from the fully resolved last stage.
    assign raw   = r_q[LAST];
    assign ovf_w = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                 & (raw[WIDTH-1] != a_q[LAST][WIDTH-1]);

    assign bus.out_valid = v_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = ovf_w;
    assign bus.sum       = (sat_q[LAST] & ovf_w)
                         ? (a_q[LAST][WIDTH-1] ? SMIN : SMAX)
                         : raw;
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; the next generation of the team's 4-bit ripple adder.
- WIDTH-bit operands are split into CHUNK-bit slices, one slice resolved per pipeline stage with carry registered between stages.
- Adds subtract mode, optional signed saturation, carry/overflow flags and valid/ready flow control on both sides.
- Sits between operand producers and result consumers in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (≥1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; low freezes all state.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B; 1: A−B.
- sat  input  1  1: clamp result on signed overflow.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  signed overflow of unsaturated result.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, out_valid 0, sum 0, cout 0, ovf 0, internal carries/partials 0. Deassertion is sampled on the clk edge; first accept is possible on the first enabled edge after release.
- Advance condition: adv = ena & (~out_valid | out_ready). in_ready = adv (combinational; no dependence on in_valid).
- Accept: in_valid & in_ready on a rising edge captures a, b, sub and sat into stage 0.
- Arithmetic: effective B = sub ? ~b : b; carry-in = sub.
  - Stage k adds slice [k*CHUNK +: CHUNK] plus the carry from stage k−1 (stage 0 uses carry-in).
  - Upper slices of a, b and the control bits travel unmodified with their stage; lower result slices travel forward.
- Final stage computes:
  - cout = carry out of bit WIDTH−1.
  - ovf = (A[MSB] == effB[MSB]) & (raw[MSB] != A[MSB]).
  - If sat & ovf: sum = A[MSB] ? {1,0…0} : {0,1…1}. Otherwise sum = raw.
  - ovf reports overflow even when saturated; cout is always from the raw sum.
- Latency: exactly STAGES enabled, non-stalled edges from accept to out_valid = 1. Throughput: 1 result per cycle when out_ready is held high.
- Ordering: results leave in acceptance order; no reordering, no drops, no duplicates.
- Stall (out_valid & ~out_ready): the whole pipeline holds; sum, cout and ovf stay stable; in_ready = 0.
- Simultaneous out_ready and in_valid while full: the output transfers and the new operand is accepted on the same edge.
- ena low: no state changes and in_ready = 0. out_valid and sum hold their values; the consumer may still see out_valid but no transfer completes.
- Bubbles: a stage with valid 0 still shifts when adv is high; there is no bubble collapsing.
- Wrap-around: unsigned results wrap modulo 2^WIDTH when sat = 0.
- Reset mid-operation: all in-flight results are discarded; no out_valid is produced for them.

Test Plan:
- WIDTH=8, CHUNK=4, out_ready=1: a=0x5A, b=0x3C, sub=0, sat=0 -> 2 cycles later out_valid=1, sum=0x96, cout=0, ovf=1. Same operands with sat=1 -> sum=0x7F, ovf=1.
- a=0xFF, b=0x01, add -> sum=0x00, cout=1, ovf=0. a=0x10, b=0x20, sub -> sum=0xF0, cout=0, ovf=0.
- a=0x80, b=0x01, sub, sat=1 -> sum=0x80, ovf=1, cout=1. Same with sat=0 -> sum=0x7F.
- Streaming: 20 back-to-back random operand pairs with out_ready=1 -> one result per cycle after 2-cycle fill; every result matches the reference model, in order.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 once out_valid is high, sum held stable, no loss. On release, all queued results emerge in order.
- Reset pulse with 2 operations in flight -> outputs 0 immediately (asynchronous), no stale out_valid afterwards. Toggle ena low for 3 cycles mid-stream -> latency extends by 3 and results are unchanged.
